// File: rtl/pipeline_controle_hazard.sv
// Control-word pipeline (ID/EX, EX/MEM, MEM/WB) with load-use / RAW hazard
// detection, branch flush, operand forwarding selects and saturating event counters.
module pipeline_controle_hazard #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALUCTL_W   = 4,
  parameter bit          FWD_EN     = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_RegWrite,
  input  logic                  id_MemRead,
  input  logic                  id_MemWrite,
  input  logic                  id_MemtoReg,
  input  logic                  id_ALUSrc,
  input  logic                  id_Branch,
  input  logic                  id_Jump,
  input  logic [ALUCTL_W-1:0]   id_ALUControl,
  input  logic                  ex_redirect,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  ex_ALUSrc,
  output logic                  ex_Branch,
  output logic                  ex_Jump,
  output logic                  ex_MemRead,
  output logic                  ex_MemWrite,
  output logic                  ex_MemtoReg,
  output logic                  ex_RegWrite,
  output logic [ALUCTL_W-1:0]   ex_ALUControl,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_MemRead,
  output logic                  mem_MemWrite,
  output logic                  mem_MemtoReg,
  output logic                  mem_RegWrite,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_MemtoReg,
  output logic                  wb_RegWrite,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef struct packed {
    logic                  alu_src;
    logic                  branch;
    logic                  jump;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [ALUCTL_W-1:0]   alu_ctl;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  uses_rs1;
    logic                  uses_rs2;
  } id_ex_t;

  typedef struct packed {
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
  } mem_wb_t;

  localparam logic [CNT_W-1:0] CntMax = '1;

  id_ex_t           id_word;
  id_ex_t           id_ex_q;
  ex_mem_t          ex_mem_q;
  mem_wb_t          mem_wb_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic             ex_hit;
  logic             mem_hit;
  logic             stall_raw;
  logic             stall_req;
  logic             stall_eff;
  logic             flush;
  logic             bubble;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;

  // x0 is never a real producer, so rd==0 can neither stall nor forward.
  function automatic logic src_match(input logic [REG_ADDR_W-1:0] rs,
                                     input logic                  uses,
                                     input logic                  wr,
                                     input logic [REG_ADDR_W-1:0] rd);
    return wr && (rd != '0) && uses && (rs == rd);
  endfunction

  assign id_word = '{
    alu_src:    id_ALUSrc,
    branch:     id_Branch,
    jump:       id_Jump,
    mem_read:   id_MemRead,
    mem_write:  id_MemWrite,
    mem_to_reg: id_MemtoReg,
    reg_write:  id_RegWrite,
    alu_ctl:    id_ALUControl,
    rs1:        id_rs1,
    rs2:        id_rs2,
    rd:         id_rd,
    uses_rs1:   id_uses_rs1,
    uses_rs2:   id_uses_rs2
  };

  // Hazard detection against the instruction currently in ID.
  assign ex_hit  = src_match(id_rs1, id_uses_rs1, id_ex_q.reg_write, id_ex_q.rd) |
                   src_match(id_rs2, id_uses_rs2, id_ex_q.reg_write, id_ex_q.rd);
  assign mem_hit = src_match(id_rs1, id_uses_rs1, ex_mem_q.reg_write, ex_mem_q.rd) |
                   src_match(id_rs2, id_uses_rs2, ex_mem_q.reg_write, ex_mem_q.rd);

  // Without forwarding, WB is still safe because the register file writes before it reads.
  assign stall_raw = FWD_EN ? (id_ex_q.mem_read & ex_hit) : (ex_hit | mem_hit);

  assign flush     = ex_redirect & reset;
  assign stall_req = stall_raw & reset;
  assign stall_eff = stall_req & ~flush;
  assign bubble    = stall_req | flush;

  assign pc_write    = ~stall_eff;
  assign if_id_write = ~stall_eff;
  assign if_id_flush = flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_ex_q     <= '0;
      ex_mem_q    <= '0;
      mem_wb_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bubble) begin
        id_ex_q <= '0;
      end else begin
        id_ex_q <= id_word;
      end
      ex_mem_q <= '{
        mem_read:   id_ex_q.mem_read,
        mem_write:  id_ex_q.mem_write,
        mem_to_reg: id_ex_q.mem_to_reg,
        reg_write:  id_ex_q.reg_write,
        rd:         id_ex_q.rd
      };
      mem_wb_q <= '{
        mem_to_reg: ex_mem_q.mem_to_reg,
        reg_write:  ex_mem_q.reg_write,
        rd:         ex_mem_q.rd
      };
      if (stall_eff && (stall_cnt_q != CntMax)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush && (flush_cnt_q != CntMax)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  // Forwarding: the younger producer (EX/MEM) wins over MEM/WB.
  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (FWD_EN) begin
      if (src_match(id_ex_q.rs1, id_ex_q.uses_rs1, ex_mem_q.reg_write, ex_mem_q.rd)) begin
        fwd_a_sel = 2'b10;
      end else if (src_match(id_ex_q.rs1, id_ex_q.uses_rs1, mem_wb_q.reg_write,
                             mem_wb_q.rd)) begin
        fwd_a_sel = 2'b01;
      end
      if (src_match(id_ex_q.rs2, id_ex_q.uses_rs2, ex_mem_q.reg_write, ex_mem_q.rd)) begin
        fwd_b_sel = 2'b10;
      end else if (src_match(id_ex_q.rs2, id_ex_q.uses_rs2, mem_wb_q.reg_write,
                             mem_wb_q.rd)) begin
        fwd_b_sel = 2'b01;
      end
    end
  end

  assign fwd_a = fwd_a_sel;
  assign fwd_b = fwd_b_sel;

  assign ex_ALUSrc     = id_ex_q.alu_src;
  assign ex_Branch     = id_ex_q.branch;
  assign ex_Jump       = id_ex_q.jump;
  assign ex_MemRead    = id_ex_q.mem_read;
  assign ex_MemWrite   = id_ex_q.mem_write;
  assign ex_MemtoReg   = id_ex_q.mem_to_reg;
  assign ex_RegWrite   = id_ex_q.reg_write;
  assign ex_ALUControl = id_ex_q.alu_ctl;
  assign ex_rd         = id_ex_q.rd;

  assign mem_MemRead  = ex_mem_q.mem_read;
  assign mem_MemWrite = ex_mem_q.mem_write;
  assign mem_MemtoReg = ex_mem_q.mem_to_reg;
  assign mem_RegWrite = ex_mem_q.reg_write;
  assign mem_rd       = ex_mem_q.rd;

  assign wb_MemtoReg = mem_wb_q.mem_to_reg;
  assign wb_RegWrite = mem_wb_q.reg_write;
  assign wb_rd       = mem_wb_q.rd;

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_controle_hazard.sv
// Bench for pipeline_controle_hazard: three instances (forwarding, no forwarding,
// 2-bit counters) driven by shared directed instruction streams, checked against a stage model.
module tb_pipeline_controle_hazard;

  typedef struct packed {
    logic       rw;
    logic       mr;
    logic       mw;
    logic       m2r;
    logic       src;
    logic       br;
    logic       jp;
    logic [3:0] alu;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       u1;
    logic       u2;
  } ins_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic ex_redirect;
  ins_t cur;

  wire [38:0] obs    [3];
  wire [15:0] scnt_o [3];
  wire [15:0] fcnt_o [3];

  // Instance 0: forwarding, 16-bit counters; 1: no forwarding; 2: forwarding, 2-bit counters.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam bit          Fen = (g != 1);
    localparam int unsigned Cw  = (g == 2) ? 2 : 16;
    wire [38:0]   o;
    wire [Cw-1:0] sc;
    wire [Cw-1:0] fc;

    pipeline_controle_hazard #(
      .REG_ADDR_W(5),
      .ALUCTL_W  (4),
      .FWD_EN    (Fen),
      .CNT_W     (Cw)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .id_rs1       (cur.rs1),
      .id_rs2       (cur.rs2),
      .id_rd        (cur.rd),
      .id_uses_rs1  (cur.u1),
      .id_uses_rs2  (cur.u2),
      .id_RegWrite  (cur.rw),
      .id_MemRead   (cur.mr),
      .id_MemWrite  (cur.mw),
      .id_MemtoReg  (cur.m2r),
      .id_ALUSrc    (cur.src),
      .id_Branch    (cur.br),
      .id_Jump      (cur.jp),
      .id_ALUControl(cur.alu),
      .ex_redirect  (ex_redirect),
      .pc_write     (o[38]),
      .if_id_write  (o[37]),
      .if_id_flush  (o[36]),
      .ex_ALUSrc    (o[35]),
      .ex_Branch    (o[34]),
      .ex_Jump      (o[33]),
      .ex_MemRead   (o[32]),
      .ex_MemWrite  (o[31]),
      .ex_MemtoReg  (o[30]),
      .ex_RegWrite  (o[29]),
      .ex_ALUControl(o[28:25]),
      .ex_rd        (o[24:20]),
      .mem_MemRead  (o[19]),
      .mem_MemWrite (o[18]),
      .mem_MemtoReg (o[17]),
      .mem_RegWrite (o[16]),
      .mem_rd       (o[15:11]),
      .wb_MemtoReg  (o[10]),
      .wb_RegWrite  (o[9]),
      .wb_rd        (o[8:4]),
      .fwd_a        (o[3:2]),
      .fwd_b        (o[1:0]),
      .stall_cnt    (sc),
      .flush_cnt    (fc)
    );

    assign obs[g]    = o;
    assign scnt_o[g] = 16'(sc);
    assign fcnt_o[g] = 16'(fc);
  end

  // Model: each stage simply holds the instruction that occupies it.
  ins_t        ex_s  [3];
  ins_t        mem_s [3];
  ins_t        wb_s  [3];
  int unsigned sc_m  [3];
  int unsigned fc_m  [3];

  int n_vec = 0;
  int n_err = 0;

  function automatic bit fen(input int k);
    return k != 1;
  endfunction

  function automatic int unsigned cmax(input int k);
    return (k == 2) ? 3 : 65535;
  endfunction

  function automatic logic hits(input ins_t s, input logic [4:0] r, input logic u);
    return s.rw && (s.rd != 5'd0) && u && (r == s.rd);
  endfunction

  function automatic logic [1:0] fsel(input int k, input logic [4:0] r, input logic u);
    if (!fen(k)) return 2'b00;
    if (hits(mem_s[k], r, u)) return 2'b10;
    if (hits(wb_s[k], r, u)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called once per negedge: compare every instance, then advance the model.
  task automatic model_cycle();
    for (int k = 0; k < 3; k++) begin
      logic        s;
      logic        f;
      logic        ld;
      logic        mm;
      logic [38:0] e;
      if (!reset) begin
        ex_s[k]  = '0;
        mem_s[k] = '0;
        wb_s[k]  = '0;
        sc_m[k]  = 0;
        fc_m[k]  = 0;
      end
      ld = hits(ex_s[k], cur.rs1, cur.u1) || hits(ex_s[k], cur.rs2, cur.u2);
      mm = hits(mem_s[k], cur.rs1, cur.u1) || hits(mem_s[k], cur.rs2, cur.u2);
      s  = reset && (fen(k) ? (ex_s[k].mr && ld) : (ld || mm));
      f  = reset && ex_redirect;
      e  = {f || !s, f || !s, f,
            ex_s[k].src, ex_s[k].br, ex_s[k].jp, ex_s[k].mr, ex_s[k].mw, ex_s[k].m2r,
            ex_s[k].rw, ex_s[k].alu, ex_s[k].rd,
            mem_s[k].mr, mem_s[k].mw, mem_s[k].m2r, mem_s[k].rw, mem_s[k].rd,
            wb_s[k].m2r, wb_s[k].rw, wb_s[k].rd,
            fsel(k, ex_s[k].rs1, ex_s[k].u1), fsel(k, ex_s[k].rs2, ex_s[k].u2)};
      chk($sformatf("u%0d.outputs", k), 64'(obs[k]), 64'(e));
      chk($sformatf("u%0d.counters", k), {32'd0, scnt_o[k], fcnt_o[k]},
          {32'd0, 16'(sc_m[k]), 16'(fc_m[k])});
      if (reset) begin
        wb_s[k]  = mem_s[k];
        mem_s[k] = ex_s[k];
        if (s || f) ex_s[k] = '0;
        else        ex_s[k] = cur;
        if (f) begin
          if (fc_m[k] < cmax(k)) fc_m[k]++;
        end else if (s) begin
          if (sc_m[k] < cmax(k)) sc_m[k]++;
        end
      end
    end
  endtask

  function automatic ins_t i_lw(input logic [4:0] rd, input logic [4:0] rs1);
    ins_t t = '0;
    t.rw = 1'b1; t.mr = 1'b1; t.m2r = 1'b1; t.src = 1'b1; t.alu = 4'b0010;
    t.rd = rd; t.rs1 = rs1; t.u1 = 1'b1;
    return t;
  endfunction

  function automatic ins_t i_addi(input logic [4:0] rd, input logic [4:0] rs1);
    ins_t t = '0;
    t.rw = 1'b1; t.src = 1'b1; t.alu = 4'b0010; t.rd = rd; t.rs1 = rs1; t.u1 = 1'b1;
    return t;
  endfunction

  function automatic ins_t i_rr(input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [3:0] alu);
    ins_t t = '0;
    t.rw = 1'b1; t.alu = alu; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
    t.u1 = 1'b1; t.u2 = 1'b1;
    return t;
  endfunction

  function automatic ins_t i_sw(input logic [4:0] rs1, input logic [4:0] rs2);
    ins_t t = '0;
    t.mw = 1'b1; t.src = 1'b1; t.alu = 4'b0010; t.rs1 = rs1; t.rs2 = rs2;
    t.u1 = 1'b1; t.u2 = 1'b1;
    return t;
  endfunction

  function automatic ins_t i_beq(input logic [4:0] rs1, input logic [4:0] rs2);
    ins_t t = '0;
    t.br = 1'b1; t.alu = 4'b0110; t.rs1 = rs1; t.rs2 = rs2; t.u1 = 1'b1; t.u2 = 1'b1;
    return t;
  endfunction

  function automatic ins_t i_jal(input logic [4:0] rd);
    ins_t t = '0;
    t.jp = 1'b1; t.rw = 1'b1; t.rd = rd;
    return t;
  endfunction

  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;

  // One ID cycle: present inputs after the edge, check at the following negedge.
  task automatic cyc(input ins_t i, input logic r);
    @(posedge clk);
    #1;
    cur         = i;
    ex_redirect = r;
    @(negedge clk);
    model_cycle();
    #1;
  endtask

  // Drop reset mid-cycle and confirm the pipeline clears before any clock edge.
  task automatic pulse_reset();
    @(posedge clk);
    #2;
    reset       = 1'b0;
    cur         = '0;
    ex_redirect = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d.async_pipe", k), 64'(obs[k][35:0]), 64'd0);
      chk($sformatf("u%0d.async_ctl", k), 64'(obs[k][38:36]), 64'(3'b110));
      chk($sformatf("u%0d.async_cnt", k), {32'd0, scnt_o[k], fcnt_o[k]}, 64'd0);
    end
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    model_cycle();
  endtask

  initial begin
    reset       = 1'b1;
    ex_redirect = 1'b0;
    cur         = '0;
    for (int k = 0; k < 3; k++) begin
      ex_s[k] = '0; mem_s[k] = '0; wb_s[k] = '0; sc_m[k] = 0; fc_m[k] = 0;
    end
    pulse_reset();

    // Load-use with forwarding: one bubble, then MEM/WB forward.
    cyc(i_lw(5'd5, 5'd1), 1'b0);
    cyc(i_rr(5'd6, 5'd5, 5'd2, AluAdd), 1'b0);
    chk("lu.stall_en", 64'(obs[0][38:37]), 64'(2'b00));
    cyc(i_rr(5'd6, 5'd5, 5'd2, AluAdd), 1'b0);
    chk("lu.ex_bubble", 64'(obs[0][35:20]), 64'd0);
    chk("lu.resume_en", 64'(obs[0][38:37]), 64'(2'b11));
    cyc('0, 1'b0);
    chk("lu.fwd_a", 64'(obs[0][3:2]), 64'(2'b01));
    chk("lu.stall_cnt", 64'(scnt_o[0]), 64'd1);
    chk("lu.nofwd_stall_cnt", 64'(scnt_o[1]), 64'd2);

    // Reset with work in flight.
    cyc(i_addi(5'd3, 5'd1), 1'b0);
    cyc(i_lw(5'd9, 5'd2), 1'b0);
    pulse_reset();

    // Back-to-back ALU producers: MEM beats WB, no stall.
    cyc(i_addi(5'd3, 5'd1), 1'b0);
    cyc(i_addi(5'd3, 5'd1), 1'b0);
    cyc(i_rr(5'd4, 5'd3, 5'd3, AluAdd), 1'b0);
    chk("raw.no_stall", 64'(obs[0][38:37]), 64'(2'b11));
    cyc('0, 1'b0);
    chk("raw.fwd_ab", 64'(obs[0][3:0]), 64'(4'b1010));
    chk("raw.stall_cnt", 64'(scnt_o[0]), 64'd0);

    // Same shape with x0 producers: nothing matches, even without forwarding.
    pulse_reset();
    cyc(i_addi(5'd0, 5'd1), 1'b0);
    cyc(i_addi(5'd0, 5'd1), 1'b0);
    cyc(i_rr(5'd4, 5'd0, 5'd0, AluAdd), 1'b0);
    chk("x0.nofwd_no_stall", 64'(obs[1][38:37]), 64'(2'b11));
    cyc('0, 1'b0);
    chk("x0.fwd_ab", 64'(obs[0][3:0]), 64'd0);
    chk("x0.nofwd_stall_cnt", 64'(scnt_o[1]), 64'd0);

    // Redirect coinciding with load-use: flush wins.
    pulse_reset();
    cyc(i_lw(5'd5, 5'd1), 1'b0);
    cyc(i_rr(5'd6, 5'd5, 5'd2, AluAdd), 1'b1);
    chk("fl.ctl", 64'(obs[0][38:36]), 64'(3'b111));
    cyc('0, 1'b0);
    chk("fl.counters", {32'd0, scnt_o[0], fcnt_o[0]}, 64'h1);
    chk("fl.ex_bubble", 64'(obs[0][35:20]), 64'd0);
    cyc('0, 1'b1);
    cyc('0, 1'b1);
    chk("fl.consecutive", 64'(obs[0][36]), 64'd1);
    cyc('0, 1'b0);
    chk("fl.flush_cnt", 64'(fcnt_o[0]), 64'd3);

    // No forwarding: EX dependency stalls twice.
    pulse_reset();
    cyc(i_rr(5'd6, 5'd1, 5'd2, AluAdd), 1'b0);
    cyc(i_rr(5'd7, 5'd6, 5'd1, AluSub), 1'b0);
    chk("nf.stall1", 64'(obs[1][38:37]), 64'(2'b00));
    cyc(i_rr(5'd7, 5'd6, 5'd1, AluSub), 1'b0);
    chk("nf.stall2", 64'(obs[1][38:37]), 64'(2'b00));
    chk("nf.fwd_inst_fwd", 64'(obs[0][3:0]), 64'(4'b1000));
    cyc(i_rr(5'd7, 5'd6, 5'd1, AluSub), 1'b0);
    chk("nf.release", 64'(obs[1][38:37]), 64'(2'b11));
    cyc('0, 1'b0);
    chk("nf.fwd_tied", 64'(obs[1][3:0]), 64'd0);
    chk("nf.stall_cnt", 64'(scnt_o[1]), 64'd2);

    // Five load-use stalls: the 2-bit counter saturates at 3.
    pulse_reset();
    for (int n = 0; n < 5; n++) begin
      cyc(i_lw(5'd5, 5'd1), 1'b0);
      cyc(i_rr(5'd6, 5'd5, 5'd2, AluAdd), 1'b0);
      cyc(i_rr(5'd6, 5'd5, 5'd2, AluAdd), 1'b0);
      if (n == 3) chk("sat.reached", 64'(scnt_o[2]), 64'd3);
    end
    cyc('0, 1'b0);
    cyc('0, 1'b0);
    chk("sat.hold", 64'(scnt_o[2]), 64'd3);
    chk("sat.wide_cnt", 64'(scnt_o[0]), 64'd5);

    // Store, branch and jump control bits through the stages.
    cyc(i_sw(5'd1, 5'd2), 1'b0);
    cyc(i_beq(5'd1, 5'd2), 1'b0);
    cyc(i_jal(5'd1), 1'b0);
    chk("mix.ex_branch", 64'(obs[0][34]), 64'd1);
    cyc('0, 1'b0);
    chk("mix.ex_jump_rd", 64'({obs[0][33], obs[0][29], obs[0][24:20]}), 64'(7'b1100001));
    cyc('0, 1'b0);
    cyc('0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
